// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (requesters plus the RAM instance).
interface dmem_arbiter_if;
  logic        REQ0;
  logic        REQ1;
  logic        WE0;
  logic        WE1;
  logic [31:0] ADDR0;
  logic [31:0] ADDR1;
  logic [31:0] WDATA0;
  logic [31:0] WDATA1;
  logic [31:0] RDATA0;
  logic [31:0] RDATA1;
  logic        ACK0;
  logic        ACK1;
  logic        ERR0;
  logic        ERR1;
  logic        RAM_READ;
  logic        RAM_WRITE;
  logic [9:0]  RAM_ADDRESS;
  logic [31:0] RAM_DATAIN;
  logic [31:0] RAM_DATAOUT;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_DATAOUT,
    output RDATA0, RDATA1, ACK0, ACK1, ERR0, ERR1,
           RAM_READ, RAM_WRITE, RAM_ADDRESS, RAM_DATAIN
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, RAM_DATAOUT,
    input  RDATA0, RDATA1, ACK0, ACK1, ERR0, ERR1,
           RAM_READ, RAM_WRITE, RAM_ADDRESS, RAM_DATAIN
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between the CPU core
// (port 0) and a secondary master (port 1). The grant is registered; the
// access itself (strobes, ACK/ERR, read data) happens combinationally in the
// grant cycle. Misaligned or out-of-range accesses are acknowledged with ERR
// and never reach the RAM.
module dmem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic           CLK,
  input  logic           RESET_N,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;   // most recently served port; 1 after reset so port 0 wins the first tie
  logic   w_bad0;
  logic   w_bad1;
  logic   w_ack0;
  logic   w_ack1;
  logic   w_rd0;
  logic   w_rd1;

  assign w_bad0 = (bus.ADDR0[1:0] != 2'b00) || (bus.ADDR0 >= ADDR_LIMIT);
  assign w_bad1 = (bus.ADDR1[1:0] != 2'b00) || (bus.ADDR1 >= ADDR_LIMIT);

  assign bus.ACK0 = w_ack0;
  assign bus.ACK1 = w_ack1;

  // Grant state and last-served port.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_ack0) begin
        r_last <= 1'b0;
      end else if (w_ack1) begin
        r_last <= 1'b1;
      end
    end
  end

  // Next grant plus the same-cycle access performed by the current owner.
  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next          = IDLE;
    w_ack0          = 1'b0;
    w_ack1          = 1'b0;
    w_rd0           = 1'b0;
    w_rd1           = 1'b0;
    bus.ERR0        = 1'b0;
    bus.ERR1        = 1'b0;
    bus.RDATA0      = '0;
    bus.RDATA1      = '0;
    bus.RAM_READ    = 1'b0;
    bus.RAM_WRITE   = 1'b0;
    bus.RAM_ADDRESS = '0;
    bus.RAM_DATAIN  = '0;

    unique case (r_state)
      IDLE: begin
        if (bus.REQ0 && bus.REQ1) begin
          w_next = r_last ? GNT0 : GNT1;
        end else if (bus.REQ0) begin
          w_next = GNT0;
        end else if (bus.REQ1) begin
          w_next = GNT1;
        end
      end

      GNT0: begin
        bus.RAM_ADDRESS = bus.ADDR0[11:2];
        bus.RAM_DATAIN  = bus.WDATA0;
        if (bus.REQ0) begin
          w_ack0        = 1'b1;
          w_rd0         = ~bus.WE0 & ~w_bad0;
          bus.ERR0      = w_bad0;
          bus.RAM_WRITE = bus.WE0 & ~w_bad0;
          bus.RAM_READ  = w_rd0;
          if (w_rd0) begin
            bus.RDATA0 = bus.RAM_DATAOUT;
          end
          // Never hold the RAM twice in a row: hand over or go idle.
          w_next = bus.REQ1 ? GNT1 : IDLE;
        end
      end

      GNT1: begin
        bus.RAM_ADDRESS = bus.ADDR1[11:2];
        bus.RAM_DATAIN  = bus.WDATA1;
        if (bus.REQ1) begin
          w_ack1        = 1'b1;
          w_rd1         = ~bus.WE1 & ~w_bad1;
          bus.ERR1      = w_bad1;
          bus.RAM_WRITE = bus.WE1 & ~w_bad1;
          bus.RAM_READ  = w_rd1;
          if (w_rd1) begin
            bus.RDATA1 = bus.RAM_DATAOUT;
          end
          w_next = bus.REQ0 ? GNT0 : IDLE;
        end
      end

      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic from two protocol-abiding requesters, checked every
// cycle against a transaction-level reference model and a shadow memory.
module tb_dmem_arbiter;
  localparam logic [31:0] LIMIT = 32'h0000_1000;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // RAM instance model: synchronous write, combinational read.
  logic [31:0] ram [1024];
  bit          ram_init = 1'b0;
  assign bus.RAM_DATAOUT = ram[bus.RAM_ADDRESS];
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pattern(i);
      ram_init <= 1'b1;
    end else if (bus.RAM_WRITE) begin
      ram[bus.RAM_ADDRESS] <= bus.RAM_DATAIN;
    end
  end

  function automatic logic [31:0] pattern(input int idx);
    return 32'hA5A5_0000 ^ (idx * 32'h0101_0107);
  endfunction

  // Requester-side stimulus state.
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  // Reference model: shadow memory, port that owns the RAM in the current
  // cycle (-1 = nobody), and the last port served.
  logic [31:0] ref_mem [1024];
  int          m_owner;
  int          m_last;
  int          exp_served;
  bit          exp_write;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic apply();
    bus.REQ0 = req[0];  bus.WE0 = we[0];  bus.ADDR0 = addr[0];  bus.WDATA0 = wdata[0];
    bus.REQ1 = req[1];  bus.WE1 = we[1];  bus.ADDR1 = addr[1];  bus.WDATA1 = wdata[1];
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    req[p] = r;  we[p] = w;  addr[p] = a;  wdata[p] = d;
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".ack0"},  32'(bus.ACK0), 0);
    check({tag, ".ack1"},  32'(bus.ACK1), 0);
    check({tag, ".err0"},  32'(bus.ERR0), 0);
    check({tag, ".err1"},  32'(bus.ERR1), 0);
    check({tag, ".rd0"},   bus.RDATA0, 0);
    check({tag, ".rd1"},   bus.RDATA1, 0);
    check({tag, ".rread"}, 32'(bus.RAM_READ), 0);
    check({tag, ".rwr"},   32'(bus.RAM_WRITE), 0);
    check({tag, ".radr"},  32'(bus.RAM_ADDRESS), 0);
    check({tag, ".rdin"},  bus.RAM_DATAIN, 0);
  endtask

  // Compare every output against what the owner's access must produce.
  task automatic check_outputs(input string tag);
    logic [31:0] e_rd  [2];
    logic        e_ack [2];
    logic        e_err [2];
    logic        e_rr, e_rw;
    logic [9:0]  e_ad;
    logic [31:0] e_di;
    int          o;
    bit          bad;
    e_rd  = '{0, 0};  e_ack = '{0, 0};  e_err = '{0, 0};
    e_rr  = 0;  e_rw = 0;  e_ad = '0;  e_di = '0;
    exp_served = -1;
    exp_write  = 0;
    if (m_owner >= 0) begin
      o    = m_owner;
      e_ad = addr[o][11:2];
      e_di = wdata[o];
      if (req[o]) begin
        bad        = is_bad(addr[o]);
        exp_served = o;
        e_ack[o]   = 1'b1;
        e_err[o]   = bad;
        e_rw       = we[o] & ~bad;
        e_rr       = ~we[o] & ~bad;
        if (e_rr) e_rd[o] = ref_mem[addr[o][11:2]];
        exp_write  = e_rw;
      end
    end
    check({tag, ".ack0"},  32'(bus.ACK0), 32'(e_ack[0]));
    check({tag, ".ack1"},  32'(bus.ACK1), 32'(e_ack[1]));
    check({tag, ".err0"},  32'(bus.ERR0), 32'(e_err[0]));
    check({tag, ".err1"},  32'(bus.ERR1), 32'(e_err[1]));
    check({tag, ".rd0"},   bus.RDATA0, e_rd[0]);
    check({tag, ".rd1"},   bus.RDATA1, e_rd[1]);
    check({tag, ".rread"}, 32'(bus.RAM_READ), 32'(e_rr));
    check({tag, ".rwr"},   32'(bus.RAM_WRITE), 32'(e_rw));
    check({tag, ".radr"},  32'(bus.RAM_ADDRESS), 32'(e_ad));
    check({tag, ".rdin"},  bus.RAM_DATAIN, e_di);
  endtask

  // Apply the rules for who owns the RAM in the next cycle.
  task automatic advance_model();
    if (exp_write) ref_mem[addr[exp_served][11:2]] = wdata[exp_served];
    if (m_owner >= 0) begin
      if (exp_served >= 0) m_last = exp_served;
      m_owner = req[1 - m_owner] ? 1 - m_owner : -1;
    end else if (req[0] && req[1]) begin
      m_owner = (m_last == 1) ? 0 : 1;
    end else if (req[0]) begin
      m_owner = 0;
    end else if (req[1]) begin
      m_owner = 1;
    end
  endtask

  // One clock cycle: check mid-cycle, then let the edge happen and update.
  task automatic step(input string tag);
    @(negedge CLK);
    check_outputs(tag);
    @(posedge CLK);
    #1;
    advance_model();
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return {26'(0), 4'($urandom_range(0, 15)), 2'b00};
    else if (sel == 7) return {26'(0), 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    else if (sel == 8) return LIMIT + ($urandom & 32'h0000_0FFC);
    else               return $urandom | 32'h8000_0000;
  endfunction

  task automatic new_access(input int p);
    set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
    for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0, 0);
    apply();
    m_owner = -1;
    m_last  = 1;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1 check_all_zero("reset");
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Port 0 write 0x10 then read it back (IDLE cycle in between).
    set_port(0, 1, 1, 32'h10, 32'hDEAD_BEEF); apply();
    step("wr_idle");
    step("wr_gnt");
    set_port(0, 1, 0, 32'h10, 0); apply();
    step("rd_idle");
    step("rd_gnt");
    set_port(0, 0, 0, 0, 0); apply();
    step("idle");

    // Both ports requesting continuously: alternating grants.
    for (int k = 0; k < 8; k++) begin
      if (exp_served >= 0) new_access(exp_served);
      else begin new_access(0); new_access(1); end
      apply();
      step("tie");
    end
    for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0, 0);
    apply();
    step("drain0");
    step("drain1");

    // Late request on port 1 during port 0's grant, then a tie.
    set_port(0, 1, 0, 32'h20, 0); apply();
    step("late_idle");
    set_port(1, 1, 1, 32'h24, 32'h1234_5678); apply();
    step("late_gnt0");
    set_port(0, 0, 0, 0, 0); apply();
    step("late_gnt1");
    set_port(0, 1, 0, 32'h24, 0); set_port(1, 1, 0, 32'h20, 0); apply();
    step("late_tie_idle");
    step("late_tie_gnt");
    step("late_tie_gnt2");
    for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0, 0);
    apply();
    step("late_drain");

    // Misaligned write on port 1, out-of-range read on port 0.
    set_port(1, 1, 1, 32'h0000_0002, 32'hBAD0_BAD0); apply();
    step("mis_idle");
    step("mis_gnt");
    set_port(1, 0, 0, 0, 0); set_port(0, 1, 0, LIMIT, 0); apply();
    step("oor_idle");
    step("oor_gnt");
    set_port(0, 1, 0, 32'h0, 0); apply();
    step("mis_chk_idle");
    step("mis_chk_gnt");
    set_port(0, 0, 0, 0, 0); apply();
    step("mis_drain");

    // Reset in the middle of a write grant: the write must be lost.
    set_port(0, 1, 1, 32'h40, 32'hCAFE_F00D); apply();
    step("rst_idle");
    RESET_N = 1'b0;
    #1 check_all_zero("rst_mid");
    m_owner = -1;
    m_last  = 1;
    set_port(0, 0, 0, 0, 0); apply();
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK); #1;
    set_port(0, 1, 0, 32'h40, 0); apply();
    step("rst_rd_idle");
    step("rst_rd_gnt");
    set_port(0, 0, 0, 0, 0); apply();
    step("rst_drain");

    // Randomized traffic from two protocol-abiding requesters.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (exp_served == p) begin
          if ($urandom_range(0, 2) == 0) set_port(p, 0, 0, 0, 0);
          else new_access(p);
        end else if (!req[p] && $urandom_range(0, 3) == 0) begin
          new_access(p);
        end
      end
      apply();
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
